// File: rtl/bcd_timer_pkg.sv
// Shared types, digit limits and preset validation for the BCD timer controller.
package bcd_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ONES_MAX = 4'd9;
  localparam bcd_digit_t TENS_MAX = 4'd5;

  // A field is legal when its ones digit is decimal and the whole field does not exceed max.
  // With max=8'h59 this also bounds the tens digit to 5.
  function automatic logic bcd_field_ok(input logic [7:0] field, input logic [7:0] max);
    return (field[3:0] <= ONES_MAX) && (field <= max);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit step: returns the next value and a carry (up) or borrow (down) for the next digit.
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  bcd_digit_t digit,
  input  bcd_digit_t max,
  input  logic       en,
  input  logic       dir,
  output bcd_digit_t nxt,
  output logic       cy
);

  always_comb begin
    nxt = digit;
    cy  = 1'b0;
    if (en) begin
      if (dir) begin
        cy  = (digit == 4'd0);
        nxt = cy ? max : digit - 4'd1;
      end else begin
        cy  = (digit >= max);
        nxt = cy ? 4'd0 : digit + 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_timer_ctl.sv
// N-field base-60 BCD up/down timer with prescaler, preset load and run FSM.
// Optional lap capture (lap, lap_times, lap_valid) is built when BCD_TIMER_LAP_EN is defined.
module bcd_timer_ctl
  import bcd_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000_000,
  parameter int unsigned N_FIELDS = 2,
  parameter logic [7:0]  TOP_MAX  = 8'h59
) (
  input  logic                  clk,
  input  logic                  init_rst,
  input  logic                  rst,
  input  logic                  setting,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  dir,
  input  logic                  load,
  input  logic [8*N_FIELDS-1:0] load_val,
`ifdef BCD_TIMER_LAP_EN
  input  logic                  lap,
  output logic [8*N_FIELDS-1:0] lap_times,
  output logic                  lap_valid,
`endif
  output logic [8*N_FIELDS-1:0] times,
  output logic                  running,
  output logic                  done,
  output logic [8*N_FIELDS-1:0] time_out,
  output logic                  load_err
);

  localparam int unsigned W  = 8 * N_FIELDS;
  localparam int unsigned ND = 2 * N_FIELDS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  state_e         state_q, state_d;
  logic [W-1:0]   times_q, times_d;
  logic [W-1:0]   preset_q, preset_d;
  logic           dir_q, dir_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic           load_err_q, load_err_d;
  logic           running_q, done_q;

  logic           cnt_en, tick;
  logic [W-1:0]   term_up, times_cnt, times_step;
  logic [ND:0]    en_chain;
  logic           load_ok;

  assign cnt_en      = (state_q == RUN) && !setting;
  assign tick        = cnt_en && (presc_q == PRESC_LAST);
  assign en_chain[0] = tick;

  always_comb begin
    term_up = '0;
    for (int f = 0; f < int'(N_FIELDS); f++)
      term_up[8*f +: 8] = (f == int'(N_FIELDS) - 1) ? TOP_MAX : 8'h59;
  end

  always_comb begin
    load_ok = 1'b1;
    for (int f = 0; f < int'(N_FIELDS); f++)
      if (!bcd_field_ok(load_val[8*f +: 8], (f == int'(N_FIELDS) - 1) ? TOP_MAX : 8'h59))
        load_ok = 1'b0;
  end

  // Ripple chain of digit cells; the top field uses its own tens limit from TOP_MAX.
  for (genvar g = 0; g < int'(ND); g++) begin : g_digit
    localparam bit         IS_TOP  = ((g / 2) == int'(N_FIELDS) - 1);
    localparam bit         IS_TENS = ((g % 2) != 0);
    localparam bcd_digit_t MAXV    = IS_TENS ? (IS_TOP ? TOP_MAX[7:4] : TENS_MAX) : ONES_MAX;

    bcd_digit_cell u_cell (
      .digit (times_q[4*g +: 4]),
      .max   (MAXV),
      .en    (en_chain[g]),
      .dir   (dir_q),
      .nxt   (times_cnt[4*g +: 4]),
      .cy    (en_chain[g+1])
    );
  end

  // A carry out of the top field would wrap; hold instead so the top field saturates.
  assign times_step = en_chain[ND] ? times_q : times_cnt;

  always_comb begin
    state_d    = state_q;
    times_d    = times_q;
    preset_d   = preset_q;
    dir_d      = dir_q;
    presc_d    = presc_q;
    load_err_d = 1'b0;

    if (rst) begin
      state_d = IDLE;
      times_d = dir_q ? preset_q : '0;
      presc_d = '0;
    end else if (load && (setting || state_q != RUN)) begin
      if (load_ok) begin
        times_d  = load_val;
        preset_d = load_val;
        state_d  = IDLE;
        presc_d  = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop && state_q == RUN) begin
      state_d = PAUSE;
    end else if (start && state_q != RUN) begin
      case (state_q)
        IDLE: begin
          dir_d   = dir;
          presc_d = '0;
          if (dir ? (times_q == '0) : (times_q == term_up)) state_d = DONE;
          else                                              state_d = RUN;
        end
        PAUSE: state_d = RUN;
        DONE: begin
          // Restarting a finished countdown reloads the preset.
          if (dir_q && preset_q != '0) begin
            state_d = RUN;
            times_d = preset_q;
            presc_d = '0;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (cnt_en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        times_d = times_step;
        if (dir_q ? (times_step == '0) : (times_step == term_up)) state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init_rst) begin
      state_q    <= IDLE;
      times_q    <= '0;
      preset_q   <= '0;
      dir_q      <= 1'b0;
      presc_q    <= '0;
      load_err_q <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      times_q    <= times_d;
      preset_q   <= preset_d;
      dir_q      <= dir_d;
      presc_q    <= presc_d;
      load_err_q <= load_err_d;
      running_q  <= (state_d == RUN);
      done_q     <= (state_d == DONE);
    end
  end

  assign times    = times_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;
  assign time_out = {W{done_q & ~setting}};

`ifdef BCD_TIMER_LAP_EN
  logic [W-1:0] lap_times_q, lap_times_d;
  logic         lap_valid_q, lap_valid_d;

  always_comb begin
    lap_times_d = lap_times_q;
    lap_valid_d = lap_valid_q;
    if (rst) begin
      lap_times_d = '0;
      lap_valid_d = 1'b0;
    end else if (lap && (state_q == RUN || state_q == PAUSE)) begin
      lap_times_d = times_q;
      lap_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init_rst) begin
      lap_times_q <= '0;
      lap_valid_q <= 1'b0;
    end else begin
      lap_times_q <= lap_times_d;
      lap_valid_q <= lap_valid_d;
    end
  end

  assign lap_times = lap_times_q;
  assign lap_valid = lap_valid_q;
`endif

endmodule

// File: tb/tb_bcd_timer_ctl.sv
// Bench for bcd_timer_ctl: seconds-based reference model checked every cycle, plus literal pins.
module tb_bcd_timer_ctl;

  localparam int TICK_DIV = 4;
  localparam int MAXV     = 59 * 60 + 59;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic        clk = 1'b0;
  logic        init_rst = 1'b1;
  logic        rst = 1'b0, setting = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0, load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] times, time_out;
  logic        running, done, load_err;

  logic        rst3 = 1'b0, setting3 = 1'b0, start3 = 1'b0, stop3 = 1'b0, dir3 = 1'b0, load3 = 1'b0;
  logic [23:0] load_val3 = '0;
  logic [23:0] times3, time_out3;
  logic        running3, done3, load_err3;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_timer_ctl #(.TICK_DIV(TICK_DIV), .N_FIELDS(2), .TOP_MAX(8'h59)) u_dut (
    .clk(clk), .init_rst(init_rst), .rst(rst), .setting(setting), .start(start), .stop(stop),
    .dir(dir), .load(load), .load_val(load_val), .times(times), .running(running), .done(done),
    .time_out(time_out), .load_err(load_err)
  );

  bcd_timer_ctl #(.TICK_DIV(TICK_DIV), .N_FIELDS(3), .TOP_MAX(8'h23)) u_dut3 (
    .clk(clk), .init_rst(init_rst), .rst(rst3), .setting(setting3), .start(start3), .stop(stop3),
    .dir(dir3), .load(load3), .load_val(load_val3), .times(times3), .running(running3),
    .done(done3), .time_out(time_out3), .load_err(load_err3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dec2(input int x);
    return 8'(((x / 10) << 4) | (x % 10));
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {dec2(v / 60), dec2(v % 60)};
  endfunction

  function automatic int field_dec(input logic [7:0] f);
    return int'(f[7:4]) * 10 + int'(f[3:0]);
  endfunction

  function automatic int from_bcd(input logic [15:0] b);
    return field_dec(b[15:8]) * 60 + field_dec(b[7:0]);
  endfunction

  function automatic bit bcd_valid(input logic [15:0] b);
    return (b[3:0] <= 9) && (b[7:4] <= 5) && (b[11:8] <= 9) && (field_dec(b[15:8]) <= 59);
  endfunction

  // Reference model: the count is an integer number of seconds.
  int m_state = M_IDLE, m_val = 0, m_preset = 0, m_presc = 0;
  bit m_dir = 1'b0, m_lerr = 1'b0;

  always @(posedge clk) begin
    bit e;
    e = 1'b0;
    if (init_rst) begin
      m_state = M_IDLE; m_val = 0; m_preset = 0; m_presc = 0; m_dir = 1'b0;
    end else if (rst) begin
      m_state = M_IDLE; m_val = m_dir ? m_preset : 0; m_presc = 0;
    end else if (load && (setting || m_state != M_RUN)) begin
      if (bcd_valid(load_val)) begin
        m_val = from_bcd(load_val); m_preset = m_val; m_state = M_IDLE; m_presc = 0;
      end else e = 1'b1;
    end else if (stop && m_state == M_RUN) begin
      m_state = M_PAUSE;
    end else if (start && m_state != M_RUN) begin
      if (m_state == M_IDLE) begin
        m_dir = dir; m_presc = 0;
        m_state = ((dir && m_val == 0) || (!dir && m_val == MAXV)) ? M_DONE : M_RUN;
      end else if (m_state == M_PAUSE) begin
        m_state = M_RUN;
      end else if (m_dir && m_preset != 0) begin
        m_state = M_RUN; m_val = m_preset; m_presc = 0;
      end
    end else if (m_state == M_RUN && !setting) begin
      m_presc++;
      if (m_presc == TICK_DIV) begin
        m_presc = 0;
        m_val = m_dir ? m_val - 1 : m_val + 1;
        if ((m_dir && m_val == 0) || (!m_dir && m_val == MAXV)) m_state = M_DONE;
      end
    end
    m_lerr = e;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("times", 32'(times), 32'(to_bcd(m_val)));
      check("running", 32'(running), 32'(m_state == M_RUN));
      check("done", 32'(done), 32'(m_state == M_DONE));
      check("time_out", 32'(time_out), (m_state == M_DONE && !setting) ? 32'hFFFF : 32'h0);
      check("load_err", 32'(load_err), 32'(m_lerr));
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic d);
    start = 1'b1; dir = d; step(); start = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    setting = 1'b1; load = 1'b1; load_val = v; step(); load = 1'b0; setting = 1'b0;
  endtask

  function automatic logic [15:0] rand_load();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return 16'($urandom);
    if (r == 1) return to_bcd(MAXV - $urandom_range(0, 3));
    if (r == 2) return to_bcd($urandom_range(0, 3));
    return to_bcd($urandom_range(0, MAXV));
  endfunction

  initial begin
    repeat (2) step();
    init_rst = 1'b0;
    chk_en = 1'b1;
    check("reset_times", 32'(times), 32'h0);
    check("reset_running", 32'(running), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_time_out", 32'(time_out), 32'h0);

    // First tick exactly TICK_DIV cycles after start, then ripple through 0959 -> 1000.
    pulse_start(1'b0);
    repeat (3) step();
    check("first_tick_pre", 32'(times), 32'h0000);
    step();
    check("first_tick", 32'(times), 32'h0001);
    repeat (598 * TICK_DIV) step();
    check("tick_599", 32'(times), 32'h0959);
    repeat (TICK_DIV) step();
    check("carry_1000", 32'(times), 32'h1000);

    // Count up into the terminal value.
    do_load(16'h5958);
    check("load_5958", 32'(times), 32'h5958);
    pulse_start(1'b0);
    repeat (TICK_DIV) step();
    check("up_term_times", 32'(times), 32'h5959);
    check("up_term_done", 32'(done), 32'h1);
    check("up_term_timeout", 32'(time_out), 32'hFFFF);
    setting = 1'b1; #1;
    check("setting_masks", 32'(time_out), 32'h0);
    step(); setting = 1'b0;

    // Count down with borrow across fields, then soft clear back to the preset.
    do_load(16'h0100);
    pulse_start(1'b1);
    repeat (TICK_DIV) step();
    check("down_borrow", 32'(times), 32'h0059);
    repeat (TICK_DIV) step();
    check("down_0058", 32'(times), 32'h0058);
    repeat (58 * TICK_DIV) step();
    check("down_zero", 32'(times), 32'h0000);
    check("down_done", 32'(done), 32'h1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_preset", 32'(times), 32'h0100);
    check("rst_idle", 32'(running | done), 32'h0);

    // Pause holds both the count and the prescaler phase.
    do_load(16'h0000);
    pulse_start(1'b0);
    repeat (49) step();
    stop = 1'b1; step(); stop = 1'b0;
    repeat (20) step();
    check("pause_hold", 32'(times), 32'h0012);
    check("pause_not_running", 32'(running), 32'h0);
    pulse_start(1'b0);
    repeat (2) step();
    check("resume_pre", 32'(times), 32'h0012);
    step();
    check("resume_tick", 32'(times), 32'h0013);

    // Rejected loads and a silently ignored load during RUN.
    setting = 1'b1; load = 1'b1; load_val = 16'h0A00; step();
    check("bad_ones_err", 32'(load_err), 32'h1);
    check("bad_ones_times", 32'(times), 32'h0013);
    load_val = 16'h0060; step();
    check("bad_tens_err", 32'(load_err), 32'h1);
    check("bad_tens_times", 32'(times), 32'h0013);
    load = 1'b0; setting = 1'b0; step();
    check("err_one_cycle", 32'(load_err), 32'h0);
    load = 1'b1; load_val = 16'h0100; step(); load = 1'b0;
    check("run_load_no_err", 32'(load_err), 32'h0);
    check("run_load_ignored", 32'(running), 32'h1);

    // Start with an already-terminal value goes straight to DONE.
    do_load(16'h5959);
    pulse_start(1'b0);
    check("term_start_done", 32'(done), 32'h1);
    check("term_start_times", 32'(times), 32'h5959);
    do_load(16'h0000);
    pulse_start(1'b1);
    check("zero_down_done", 32'(done), 32'h1);
    pulse_start(1'b1);
    check("zero_preset_ignored", 32'(done), 32'h1);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 99) < 4);
      load_val = rand_load();
      stop     = ($urandom_range(0, 99) < 4);
      start    = ($urandom_range(0, 99) < 8);
      dir      = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) < 3) setting = ~setting;
      step();
    end
    rst = 1'b0; load = 1'b0; stop = 1'b0; start = 1'b0; setting = 1'b0;
    step();

    // Three-field instance with a 23 h top field.
    load3 = 1'b1; load_val3 = 24'h235958; step(); load3 = 1'b0;
    check("f3_load", 32'(times3), 32'h235958);
    start3 = 1'b1; step(); start3 = 1'b0;
    check("f3_running", 32'(running3), 32'h1);
    repeat (TICK_DIV - 1) step();
    check("f3_pre_tick", 32'(times3), 32'h235958);
    step();
    check("f3_term_times", 32'(times3), 32'h235959);
    check("f3_done", 32'(done3), 32'h1);
    check("f3_time_out", 32'(time_out3), 32'hFFFFFF);
    load3 = 1'b1; load_val3 = 24'h240000; step(); load3 = 1'b0;
    check("f3_top_reject", 32'(load_err3), 32'h1);
    check("f3_top_hold", 32'(times3), 32'h235959);

    step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
